// File: rtl/avalon_pixel_loader_if.sv
// Avalon-MM bus bundle between the host bridge and the pixel loader.
// The host drives requests and the loader returns stall, read data and response.
interface avalon_pixel_loader_if;
  logic        write;
  logic        read;
  logic        beginbursttransfer;
  logic [9:0]  burstcount;
  logic [12:0] address;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        waitrequest;
  logic        readdatavalid;
  logic [1:0]  response;

  modport slave (
    input  write, read, beginbursttransfer, burstcount, address, writedata,
    output readdata, waitrequest, readdatavalid, response
  );

  modport master (
    output write, read, beginbursttransfer, burstcount, address, writedata,
    input  readdata, waitrequest, readdatavalid, response
  );
endinterface

// File: rtl/avalon_pixel_loader.sv
// Avalon-MM slave that unpacks 4-pixel words into two-lane 16-bit SRAM writes and exposes
// control/status registers for clearing the image buffer and starting the network.
module avalon_pixel_loader #(
  parameter int unsigned NumWords   = 196,
  parameter int unsigned ControlReg = 4126,
  parameter int unsigned StatusReg  = 4127
) (
  input  logic                         clk,
  input  logic                         n_rst,
  avalon_pixel_loader_if.slave         bus,
  output logic                         w_enable_pixels,
  output logic [9:0]                   pixel_address1,
  output logic [9:0]                   pixel_address2,
  output logic [15:0]                  pixel_data1,
  output logic [15:0]                  pixel_data2,
  output logic                         start
);

  localparam logic [12:0] CtrlAddr = 13'(ControlReg);
  localparam logic [12:0] StatAddr = 13'(StatusReg);
  localparam logic [12:0] LastWord = 13'(NumWords - 1);
  localparam logic [9:0]  MaxPix   = 10'(NumWords * 4);

  typedef enum logic [1:0] {StIdle, StLo, StHi, StRd} state_e;

  state_e      state_q, state_d;
  logic        init_q, init_d;
  logic [12:0] word_q, word_d;
  logic [9:0]  beats_q, beats_d;
  logic [31:0] data_q, data_d;
  logic        drop_q, drop_d;
  logic        loaded_q, loaded_d;
  logic        error_q, error_d;
  logic [9:0]  pix_q, pix_d;
  logic        start_q, start_d;
  logic [12:0] rd_addr_q, rd_addr_d;

  logic        wait_req;
  logic        rvalid;
  logic [31:0] rdata;
  logic [1:0]  resp;
  logic        busy;
  logic        illegal;

  // RD is excluded so a status read never reports itself as busy.
  assign busy    = (state_q == StLo) || (state_q == StHi) || (beats_q != 10'd0);
  assign illegal = (bus.burstcount == 10'd0) ||
                   (({1'b0, bus.address} + {4'b0, bus.burstcount}) > 14'(NumWords));

  always_comb begin
    state_d         = state_q;
    init_d          = 1'b1;
    word_d          = word_q;
    beats_d         = beats_q;
    data_d          = data_q;
    drop_d          = drop_q;
    loaded_d        = loaded_q;
    error_d         = error_q;
    pix_d           = pix_q;
    start_d         = 1'b0;
    rd_addr_d       = rd_addr_q;
    wait_req        = 1'b1;
    rvalid          = 1'b0;
    rdata           = 32'h0;
    resp            = 2'b00;
    w_enable_pixels = 1'b0;
    pixel_address1  = 10'h0;
    pixel_address2  = 10'h0;
    pixel_data1     = 16'h0;
    pixel_data2     = 16'h0;

    unique case (state_q)
      StIdle: begin
        wait_req = ~init_q;
        if (init_q) begin
          // An open burst owns the bus: every write is its next beat.
          if (bus.write && (beats_q != 10'd0)) begin
            data_d  = bus.writedata;
            state_d = StLo;
          end else if (bus.write && bus.beginbursttransfer) begin
            word_d  = bus.address;
            beats_d = bus.burstcount;
            data_d  = bus.writedata;
            drop_d  = illegal;
            if (illegal) error_d = 1'b1;
            state_d = StLo;
          end else if (bus.write && (bus.address == CtrlAddr)) begin
            if (bus.writedata[0]) begin
              loaded_d = 1'b0;
              error_d  = 1'b0;
              pix_d    = 10'd0;
            end
            if (bus.writedata[1]) begin
              if (loaded_q && !bus.writedata[0]) start_d = 1'b1;
              else                               error_d = 1'b1;
            end
          end else if (bus.read) begin
            rd_addr_d = bus.address;
            state_d   = StRd;
          end
        end
      end
      StLo: begin
        w_enable_pixels = ~drop_q;
        pixel_address1  = {word_q[7:0], 2'b00};
        pixel_address2  = {word_q[7:0], 2'b01};
        pixel_data1     = {8'h00, data_q[7:0]};
        pixel_data2     = {8'h00, data_q[15:8]};
        state_d         = StHi;
      end
      StHi: begin
        w_enable_pixels = ~drop_q;
        pixel_address1  = {word_q[7:0], 2'b10};
        pixel_address2  = {word_q[7:0], 2'b11};
        pixel_data1     = {8'h00, data_q[23:16]};
        pixel_data2     = {8'h00, data_q[31:24]};
        word_d          = word_q + 13'd1;
        beats_d         = (beats_q > 10'd1) ? beats_q - 10'd1 : 10'd0;
        if (!drop_q) begin
          pix_d = (pix_q > MaxPix - 10'd4) ? MaxPix : pix_q + 10'd4;
          if (word_q == LastWord) loaded_d = 1'b1;
        end
        if (beats_d == 10'd0) drop_d = 1'b0;
        state_d = StIdle;
      end
      StRd: begin
        rvalid = 1'b1;
        if (rd_addr_q == StatAddr) begin
          rdata = {14'b0, pix_q, 5'b0, busy, error_q, loaded_q};
        end else if (rd_addr_q != CtrlAddr) begin
          resp = 2'b10;
        end
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q   <= StIdle;
      init_q    <= 1'b0;
      word_q    <= 13'h0;
      beats_q   <= 10'h0;
      data_q    <= 32'h0;
      drop_q    <= 1'b0;
      loaded_q  <= 1'b0;
      error_q   <= 1'b0;
      pix_q     <= 10'h0;
      start_q   <= 1'b0;
      rd_addr_q <= 13'h0;
    end else begin
      state_q   <= state_d;
      init_q    <= init_d;
      word_q    <= word_d;
      beats_q   <= beats_d;
      data_q    <= data_d;
      drop_q    <= drop_d;
      loaded_q  <= loaded_d;
      error_q   <= error_d;
      pix_q     <= pix_d;
      start_q   <= start_d;
      rd_addr_q <= rd_addr_d;
    end
  end

  assign bus.waitrequest   = wait_req;
  assign bus.readdatavalid = rvalid;
  assign bus.readdata      = rdata;
  assign bus.response      = resp;
  assign start             = start_q;

endmodule
